id_issue_queue: RTL and testbench

Parametrised instruction buffer and dual-issue selector between fetch and decode. It accepts up to FETCH_W instructions per cycle from fetch into a circular queue of DEPTH entries. It presents up to ISSUE_W in-order instructions per cycle to the decode lanes, applying MIPS pairing rules: branch plus delay slot, RAW between lanes, one memory op, one HI/LO op. It supports pipeline flush on exception, eret or branch mispredict.

---
 rtl/id_issue_queue_pkg.sv | 71 +++++++
 rtl/id_issue_queue_predec.sv | 105 ++++++++++
 rtl/id_issue_queue.sv | 127 ++++++++++++
 tb/tb_id_issue_queue.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/id_issue_queue_pkg.sv
// rtl/id_issue_queue_pkg.sv - MIPS opcode/func constants and field extractors shared by issue queue and decode
package id_issue_queue_pkg;

   localparam logic [5:0] OP_SPEC   = 6'h00;
   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_J      = 6'h02;
   localparam logic [5:0] OP_JAL    = 6'h03;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BNE    = 6'h05;
   localparam logic [5:0] OP_BLEZ   = 6'h06;
   localparam logic [5:0] OP_BGTZ   = 6'h07;
   localparam logic [5:0] OP_ADDI   = 6'h08;
   localparam logic [5:0] OP_ADDIU  = 6'h09;
   localparam logic [5:0] OP_SLTI   = 6'h0a;
   localparam logic [5:0] OP_SLTIU  = 6'h0b;
   localparam logic [5:0] OP_ANDI   = 6'h0c;
   localparam logic [5:0] OP_ORI    = 6'h0d;
   localparam logic [5:0] OP_XORI   = 6'h0e;
   localparam logic [5:0] OP_LUI    = 6'h0f;
   localparam logic [5:0] OP_COP0   = 6'h10;
   localparam logic [5:0] OP_LB     = 6'h20;
   localparam logic [5:0] OP_LH     = 6'h21;
   localparam logic [5:0] OP_LW     = 6'h23;
   localparam logic [5:0] OP_LBU    = 6'h24;
   localparam logic [5:0] OP_LHU    = 6'h25;
   localparam logic [5:0] OP_SB     = 6'h28;
   localparam logic [5:0] OP_SH     = 6'h29;
   localparam logic [5:0] OP_SW     = 6'h2b;

   localparam logic [5:0] FN_SLL     = 6'h00;
   localparam logic [5:0] FN_SRL     = 6'h02;
   localparam logic [5:0] FN_SRA     = 6'h03;
   localparam logic [5:0] FN_JR      = 6'h08;
   localparam logic [5:0] FN_JALR    = 6'h09;
   localparam logic [5:0] FN_SYSCALL = 6'h0c;
   localparam logic [5:0] FN_BREAK   = 6'h0d;
   localparam logic [5:0] FN_MFHI    = 6'h10;
   localparam logic [5:0] FN_MTHI    = 6'h11;
   localparam logic [5:0] FN_MFLO    = 6'h12;
   localparam logic [5:0] FN_MTLO    = 6'h13;
   localparam logic [5:0] FN_MULT    = 6'h18;
   localparam logic [5:0] FN_MULTU   = 6'h19;
   localparam logic [5:0] FN_DIV     = 6'h1a;
   localparam logic [5:0] FN_DIVU    = 6'h1b;
   localparam logic [5:0] FN_ERET    = 6'h18;

   localparam logic [4:0] CP0_MF = 5'h00;
   localparam logic [4:0] CP0_MT = 5'h04;
   localparam logic [4:0] RA     = 5'd31;

   function automatic logic [5:0] get_op(input logic [31:0] inst);
      return inst[31:26];
   endfunction

   function automatic logic [4:0] get_rs(input logic [31:0] inst);
      return inst[25:21];
   endfunction

   function automatic logic [4:0] get_rt(input logic [31:0] inst);
      return inst[20:16];
   endfunction

   function automatic logic [4:0] get_rd(input logic [31:0] inst);
      return inst[15:11];
   endfunction

   function automatic logic [5:0] get_func(input logic [31:0] inst);
      return inst[5:0];
   endfunction

endpackage

// File: rtl/id_issue_queue_predec.sv
// rtl/id_issue_queue_predec.sv - iq_predec: register usage and class flags for one queued instruction
module iq_predec
   import id_issue_queue_pkg::*;
(
   input  logic [31:0] inst,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic        rs_ren,
   output logic        rt_ren,
   output logic [4:0]  wreg,
   output logic        regwen,
   output logic        is_br,
   output logic        is_mem,
   output logic        is_hilo,
   output logic        is_priv
);

   logic [5:0] op;
   logic [5:0] fn;
   logic [4:0] rd;

   always_comb begin
      op      = get_op(inst);
      fn      = get_func(inst);
      rd      = get_rd(inst);
      rs      = get_rs(inst);
      rt      = get_rt(inst);
      rs_ren  = 1'b0;
      rt_ren  = 1'b0;
      wreg    = 5'd0;
      regwen  = 1'b0;
      is_br   = 1'b0;
      is_mem  = 1'b0;
      is_hilo = 1'b0;
      is_priv = 1'b0;
      case (op)
         OP_SPEC: begin
            case (fn)
               FN_SLL, FN_SRL, FN_SRA: begin
                  rt_ren = 1'b1; wreg = rd; regwen = 1'b1;
               end
               FN_JR: begin
                  rs_ren = 1'b1; is_br = 1'b1;
               end
               FN_JALR: begin
                  rs_ren = 1'b1; is_br = 1'b1; wreg = RA; regwen = 1'b1;
               end
               FN_SYSCALL, FN_BREAK: is_priv = 1'b1;
               FN_MFHI, FN_MFLO: begin
                  is_hilo = 1'b1; wreg = rd; regwen = 1'b1;
               end
               FN_MTHI, FN_MTLO: begin
                  is_hilo = 1'b1; rs_ren = 1'b1;
               end
               FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                  is_hilo = 1'b1; rs_ren = 1'b1; rt_ren = 1'b1;
               end
               default: begin
                  rs_ren = 1'b1; rt_ren = 1'b1; wreg = rd; regwen = 1'b1;
               end
            endcase
         end
         OP_REGIMM: begin
            // rt[4] selects the linking forms bltzal/bgezal
            rs_ren = 1'b1; is_br = 1'b1;
            if (rt[4]) begin
               wreg = RA; regwen = 1'b1;
            end
         end
         OP_J:   is_br = 1'b1;
         OP_JAL: begin
            is_br = 1'b1; wreg = RA; regwen = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            is_br = 1'b1; rs_ren = 1'b1; rt_ren = 1'b1;
         end
         OP_BLEZ, OP_BGTZ: begin
            is_br = 1'b1; rs_ren = 1'b1;
         end
         OP_LUI: begin
            wreg = rt; regwen = 1'b1;
         end
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
            rs_ren = 1'b1; wreg = rt; regwen = 1'b1;
         end
         OP_COP0: begin
            if (rs == CP0_MF) begin
               is_priv = 1'b1; wreg = rt; regwen = 1'b1;
            end else if (rs == CP0_MT) begin
               is_priv = 1'b1; rt_ren = 1'b1;
            end else if (inst[25] && inst[24:6] == 19'd0 && fn == FN_ERET) begin
               is_priv = 1'b1;
            end
         end
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
            is_mem = 1'b1; rs_ren = 1'b1; wreg = rt; regwen = 1'b1;
         end
         OP_SB, OP_SH, OP_SW: begin
            is_mem = 1'b1; rs_ren = 1'b1; rt_ren = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/id_issue_queue.sv
// rtl/id_issue_queue.sv - circular fetch buffer with in-order dual-issue pairing toward decode
module id_issue_queue
   import id_issue_queue_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int FETCH_W = 2,
   parameter int ISSUE_W = 2
)
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   input  logic [1:0]                in_cnt,
   input  logic [32*FETCH_W-1:0]     in_inst,
   input  logic [32*FETCH_W-1:0]     in_pc,
   output logic                      in_ready,
   input  logic                      flush,
   output logic [ISSUE_W-1:0]        out_valid,
   output logic [32*ISSUE_W-1:0]     out_inst,
   output logic [32*ISSUE_W-1:0]     out_pc,
   input  logic                      out_ready,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [31:0]   inst_q [DEPTH];
   logic [31:0]   pc_q   [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] cnt;
   logic          push;
   logic [CW-1:0] push_n;
   logic [CW-1:0] pop_n;
   logic          l0_ok;

   logic [31:0] lane_inst [ISSUE_W];
   logic [4:0]  rs        [ISSUE_W];
   logic [4:0]  rt        [ISSUE_W];
   logic        rs_ren    [ISSUE_W];
   logic        rt_ren    [ISSUE_W];
   logic [4:0]  wreg      [ISSUE_W];
   logic        regwen    [ISSUE_W];
   logic        is_br     [ISSUE_W];
   logic        is_mem    [ISSUE_W];
   logic        is_hilo   [ISSUE_W];
   logic        is_priv   [ISSUE_W];

   assign count    = cnt;
   assign in_ready = (CW'(DEPTH) - cnt) >= CW'(FETCH_W);
   assign push     = in_valid && in_ready;
   assign push_n   = push ? CW'(in_cnt) : '0;

   for (genvar i = 0; i < ISSUE_W; i++) begin : g_lane
      logic [PW-1:0] idx;
      assign idx                  = head + PW'(i);
      assign lane_inst[i]         = inst_q[idx];
      assign out_inst[32*i +: 32] = inst_q[idx];
      assign out_pc[32*i +: 32]   = pc_q[idx];

      iq_predec u_predec (
         .inst    (lane_inst[i]),
         .rs      (rs[i]),
         .rt      (rt[i]),
         .rs_ren  (rs_ren[i]),
         .rt_ren  (rt_ren[i]),
         .wreg    (wreg[i]),
         .regwen  (regwen[i]),
         .is_br   (is_br[i]),
         .is_mem  (is_mem[i]),
         .is_hilo (is_hilo[i]),
         .is_priv (is_priv[i])
      );
   end

   // A branch is held until its delay slot sits behind it in the queue
   assign l0_ok = (cnt != '0) && !(is_br[0] && cnt < CW'(2));

   if (ISSUE_W == 2) begin : g_dual
      logic raw;
      logic pair_ok;
      logic unused_pred;
      assign raw = regwen[0] && (wreg[0] != 5'd0) &&
                   ((rs_ren[1] && rs[1] == wreg[0]) || (rt_ren[1] && rt[1] == wreg[0]));
      // both-hilo also covers mfhi/mflo behind a HI/LO writer
      assign pair_ok = is_br[0] ||
                       (!is_br[1] && !is_priv[0] && !is_priv[1] &&
                        !(is_mem[0] && is_mem[1]) && !(is_hilo[0] && is_hilo[1]) && !raw);
      assign out_valid   = {l0_ok && (cnt >= CW'(2)) && pair_ok, l0_ok};
      assign unused_pred = ^{rs[0], rt[0], rs_ren[0], rt_ren[0], wreg[1], regwen[1]};
   end else begin : g_single
      logic unused_pred;
      assign out_valid   = l0_ok;
      assign unused_pred = ^{rs[0], rt[0], rs_ren[0], rt_ren[0], wreg[0], regwen[0],
                             is_mem[0], is_hilo[0], is_priv[0]};
   end

   always_comb begin
      pop_n = '0;
      for (int i = 0; i < ISSUE_W; i++) begin
         if (out_valid[i]) pop_n = pop_n + CW'(1);
      end
      if (!out_ready) pop_n = '0;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else begin
         if (push) begin
            for (int i = 0; i < FETCH_W; i++) begin
               if (i < int'(in_cnt)) begin
                  inst_q[tail + PW'(i)] <= in_inst[32*i +: 32];
                  pc_q[tail + PW'(i)]   <= in_pc[32*i +: 32];
               end
            end
         end
         tail <= tail + PW'(push_n);
         head <= head + PW'(pop_n);
         cnt  <= cnt + push_n - pop_n;
      end
   end

endmodule

// File: tb/tb_id_issue_queue.sv
// tb/tb_id_issue_queue.sv - directed self-checking bench for id_issue_queue
module tb_id_issue_queue;

   localparam logic [31:0] ADDIU1 = 32'h24010001;
   localparam logic [31:0] ADDIU2 = 32'h24020002;
   localparam logic [31:0] ADDU3  = 32'h00221821;
   localparam logic [31:0] BEQ    = 32'h10220003;
   localparam logic [31:0] NOP    = 32'h00000000;
   localparam logic [31:0] LW     = 32'h8c220000;
   localparam logic [31:0] SW     = 32'hac230004;
   localparam logic [31:0] MULT   = 32'h00220018;
   localparam logic [31:0] MFLO   = 32'h00001812;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [1:0]  in_cnt;
   logic [63:0] in_inst;
   logic [63:0] in_pc;
   logic        in_ready;
   logic        flush;
   logic [1:0]  out_valid;
   logic [63:0] out_inst;
   logic [63:0] out_pc;
   logic        out_ready;
   logic [3:0]  count;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] q[$];
   logic [31:0] next_pc;
   logic [31:0] dropped;

   always #5 clk = ~clk;

   id_issue_queue #(.DEPTH(8), .FETCH_W(2), .ISSUE_W(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_cnt    (in_cnt),
      .in_inst   (in_inst),
      .in_pc     (in_pc),
      .in_ready  (in_ready),
      .flush     (flush),
      .out_valid (out_valid),
      .out_inst  (out_inst),
      .out_pc    (out_pc),
      .out_ready (out_ready),
      .count     (count)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic enq(input logic [1:0] n, input logic [31:0] i0, input logic [31:0] p0,
                      input logic [31:0] i1, input logic [31:0] p1);
      in_valid = 1'b1;
      in_cnt   = n;
      in_inst  = {i1, i0};
      in_pc    = {p1, p0};
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_cnt = 2'd0; in_inst = '0; in_pc = '0;
      flush = 1'b0; out_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
      check("rst_count", 64'(count), 64'd0);
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_ready", 64'(in_ready), 64'd1);

      // fill a pair, then drain it
      enq(2'd2, ADDIU1, 32'hbfc00000, ADDIU2, 32'hbfc00004);
      check("fill_count", 64'(count), 64'd2);
      check("fill_valid", 64'(out_valid), 64'd3);
      check("fill_pc0", 64'(out_pc[31:0]), 64'hbfc00000);
      check("fill_pc1", 64'(out_pc[63:32]), 64'hbfc00004);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("drain_count", 64'(count), 64'd0);
      check("drain_valid", 64'(out_valid), 64'd0);

      // RAW between lanes
      enq(2'd2, ADDIU1, 32'h00000100, ADDU3, 32'h00000104);
      check("raw_valid", 64'(out_valid), 64'd1);
      out_ready = 1'b1;
      step();
      check("raw_next_valid", 64'(out_valid), 64'd1);
      check("raw_next_inst", 64'(out_inst[31:0]), 64'(ADDU3));
      check("raw_next_pc", 64'(out_pc[31:0]), 64'h104);
      step();
      out_ready = 1'b0;
      check("raw_count", 64'(count), 64'd0);

      // branch waits for its delay slot
      enq(2'd1, BEQ, 32'hbfc00010, NOP, 32'h0);
      check("br_alone_valid", 64'(out_valid), 64'd0);
      check("br_alone_count", 64'(count), 64'd1);
      enq(2'd1, NOP, 32'hbfc00014, NOP, 32'h0);
      check("br_pair_valid", 64'(out_valid), 64'd3);
      check("br_pc0", 64'(out_pc[31:0]), 64'hbfc00010);
      check("br_pc1", 64'(out_pc[63:32]), 64'hbfc00014);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("br_count", 64'(count), 64'd0);

      // fill to full across the pointer wrap, then trickle single loads through
      next_pc = 32'h00002000;
      for (int k = 0; k < 4; k++) begin
         check("full_ready_before", 64'(in_ready), 64'd1);
         enq(2'd2, LW, next_pc, LW, next_pc + 32'd4);
         q.push_back(next_pc);
         q.push_back(next_pc + 32'd4);
         next_pc = next_pc + 32'd8;
      end
      check("full_count", 64'(count), 64'd8);
      check("full_ready", 64'(in_ready), 64'd0);
      for (int c = 0; c < 10; c++) begin
         check("wrap_count", 64'(count), 64'(q.size()));
         check("wrap_ready", 64'(in_ready), 64'(q.size() <= 6));
         check("wrap_valid", 64'(out_valid), 64'd1);
         check("wrap_pc", 64'(out_pc[31:0]), 64'(q[0]));
         out_ready = 1'b1;
         in_valid  = 1'b1;
         in_cnt    = 2'd1;
         in_inst   = {NOP, LW};
         in_pc     = {32'h0, next_pc};
         if (q.size() <= 6) begin
            q.push_back(next_pc);
            next_pc = next_pc + 32'd4;
         end
         dropped = q.pop_front();
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;

      // flush with simultaneous enqueue, held for two cycles
      flush = 1'b1;
      in_valid = 1'b1; in_cnt = 2'd2; in_inst = {ADDIU2, ADDIU1}; in_pc = {32'h304, 32'h300};
      step();
      check("flush1_count", 64'(count), 64'd0);
      check("flush1_valid", 64'(out_valid), 64'd0);
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      check("flush2_count", 64'(count), 64'd0);
      check("flush2_valid", 64'(out_valid), 64'd0);
      check("flush_ready", 64'(in_ready), 64'd1);

      // one memory op per cycle
      enq(2'd2, LW, 32'h400, SW, 32'h404);
      check("mem_valid", 64'(out_valid), 64'd1);
      flush = 1'b1;
      step();
      flush = 1'b0;

      // one HI/LO op per cycle
      enq(2'd2, MULT, 32'h500, MFLO, 32'h504);
      check("hilo_valid", 64'(out_valid), 64'd1);
      check("hilo_count", 64'(count), 64'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
